// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter.
package vga_pkg;

    localparam int HACTIVE = 640;
    localparam int VACTIVE = 480;
    // Cycles from hcnt/vcnt to colour out: address register, RAM read, pixel latch.
    localparam int LAT     = 3;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage shift of the raw VGA timing so it lines up with the fetched colour.
module vga_sync_delay #(
    parameter int N = 3
) (
    input  logic vgaclk,
    input  logic reset_n,
    input  logic hsync_i,
    input  logic vsync_i,
    input  logic blank_b_i,
    output logic hsync_o,
    output logic vsync_o,
    output logic blank_b_o
);

    // Inactive timing: syncs high, display blanked.
    localparam logic [2:0] IDLE = 3'b110;

    logic [2:0] stage_q [N];
    logic [2:0] stage_d [N];

    // Shift one stage per pixel clock; stage 0 takes the raw inputs.
    always_comb begin
        stage_d[0] = {hsync_i, vsync_i, blank_b_i};
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Delay-line registers with synchronous reset to the inactive pattern.
    always_ff @(posedge vgaclk) begin
        for (int i = 0; i < N; i++) begin
            if (!reset_n) begin
                stage_q[i] <= IDLE;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign {hsync_o, vsync_o, blank_b_o} = stage_q[N-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: 4x-upscaled scan-out fetch, pixel writer port
// and a full-buffer clear sequencer sharing one 1-cycle-read RAM.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int          FB_W           = 160,
    parameter int          FB_H           = 120,
    parameter int          SCALE_SH       = 2,
    parameter int          ADDR_W         = 15,
    parameter int          DATA_W         = 16,
    parameter logic [11:0] CLR_COLOR      = 12'h000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              vgaclk,
    input  logic              reset_n,
    input  logic [9:0]        hcnt,
    input  logic [9:0]        vcnt,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              blank_b_i,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_b,
    output logic              sync_b,
    output logic [3:0]        r,
    output logic [3:0]        g,
    output logic [3:0]        b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [11:0]       wr_data,
    output logic              wr_drop,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done
);

    // state  | meaning
    // RUN    | normal operation, writer owns every non-display slot
    // CLEAR  | clear sequencer owns every non-display slot, writer stalled

    localparam int                FB_SIZE_I = FB_W * FB_H;
    // One extra bit so a buffer filling the whole address space still compares correctly.
    localparam logic [ADDR_W:0]   FB_SIZE   = (ADDR_W+1)'(FB_SIZE_I);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(FB_SIZE_I - 1);
    localparam logic [ADDR_W-1:0] FB_W_A    = ADDR_W'(FB_W);
    localparam logic [9:0]        HACT      = 10'(HACTIVE);
    localparam logic [9:0]        VACT      = 10'(VACTIVE);
    localparam logic [DATA_W-1:0] CLR_WORD  = {{(DATA_W-12){1'b0}}, CLR_COLOR};

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              wr_drop_q, wr_drop_d;
    logic              clear_done_q, clear_done_d;
    logic              clear_busy_q, clear_busy_d;
    logic [1:0]        fetch_pipe_q, fetch_pipe_d;
    rgb12_t            pix_q, pix_d;

    logic              disp_slot;
    logic [ADDR_W-1:0] fetch_addr;
    logic              wr_xfer;
    logic              wr_in_range;
    logic              clr_write;
    logic              clr_last;
    logic              unused_rdata;

    // Display slot detection and upscaled fetch address (row * FB_W + col).
    always_comb begin
        disp_slot  = (hcnt < HACT) && (vcnt < VACT) && (hcnt[SCALE_SH-1:0] == '0);
        fetch_addr = ADDR_W'(vcnt >> SCALE_SH) * FB_W_A + ADDR_W'(hcnt >> SCALE_SH);
    end

    // Writer is only offered slots the display does not need, and never while held in reset.
    assign wr_ready    = ~disp_slot & (state_q == RUN) & reset_n;
    assign wr_xfer     = wr_valid & wr_ready;
    assign wr_in_range = {1'b0, wr_addr} < FB_SIZE;
    assign clr_write   = (state_q == CLEAR) & ~disp_slot;
    assign clr_last    = (clr_addr_q == CLR_LAST);

    // FSM state register.
    always_ff @(posedge vgaclk) begin
        if (!reset_n) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a clear request is honoured only from RUN, so it cannot restart a clear.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (clear_req)             state_d = CLEAR;
            CLEAR:   if (clr_write && clr_last) state_d = RUN;
            default:                            state_d = RUN;
        endcase
    end

    // FSM outputs: pick the RAM slot owner and form the next address/data/strobe values.
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        wr_drop_d    = 1'b0;
        clear_done_d = 1'b0;
        clr_addr_d   = clr_addr_q;
        clear_busy_d = (state_q == CLEAR);
        if (disp_slot) begin
            mem_addr_d = fetch_addr;
        end else if (clr_write) begin
            mem_addr_d  = clr_addr_q;
            mem_wdata_d = CLR_WORD;
            mem_we_d    = 1'b1;
            if (clr_last) begin
                clr_addr_d   = '0;
                clear_done_d = 1'b1;
            end else begin
                clr_addr_d = clr_addr_q + 1'b1;
            end
        end else if (wr_xfer) begin
            // Out-of-range writes still complete the handshake but never reach the RAM.
            mem_addr_d  = wr_addr;
            mem_wdata_d = {{(DATA_W-12){1'b0}}, wr_data};
            mem_we_d    = wr_in_range;
            wr_drop_d   = ~wr_in_range;
        end
    end

    // Read pipeline: fetch_pipe[1] marks the cycle in which mem_rdata holds a fetched pixel.
    always_comb begin
        fetch_pipe_d = {fetch_pipe_q[0], disp_slot};
        pix_d        = fetch_pipe_q[1] ? rgb12_t'(mem_rdata[11:0]) : pix_q;
    end

    assign unused_rdata = ^mem_rdata[DATA_W-1:12];

    // Datapath registers.
    always_ff @(posedge vgaclk) begin
        if (!reset_n) begin
            clr_addr_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            wr_drop_q    <= 1'b0;
            clear_done_q <= 1'b0;
            clear_busy_q <= 1'b0;
            fetch_pipe_q <= '0;
            pix_q        <= '0;
        end else begin
            clr_addr_q   <= clr_addr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            wr_drop_q    <= wr_drop_d;
            clear_done_q <= clear_done_d;
            clear_busy_q <= clear_busy_d;
            fetch_pipe_q <= fetch_pipe_d;
            pix_q        <= pix_d;
        end
    end

    vga_sync_delay #(
        .N (LAT)
    ) u_sync_delay (
        .vgaclk    (vgaclk),
        .reset_n   (reset_n),
        .hsync_i   (hsync_i),
        .vsync_i   (vsync_i),
        .blank_b_i (blank_b_i),
        .hsync_o   (hsync),
        .vsync_o   (vsync),
        .blank_b_o (blank_b)
    );

    assign sync_b     = hsync & vsync;
    assign r          = blank_b ? pix_q.r : 4'h0;
    assign g          = blank_b ? pix_q.g : 4'h0;
    assign b          = blank_b ? pix_q.b : 4'h0;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign wr_drop    = wr_drop_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with a behavioural RAM and framebuffer model.
module tb_vga_fb_arbiter;

    localparam int FB_SIZE = 19200;
    localparam int NR      = 1500;

    logic        vgaclk = 1'b0;
    logic        reset_n;
    logic [9:0]  hcnt, vcnt;
    logic        hsync_i, vsync_i, blank_b_i;
    logic        hsync, vsync, blank_b, sync_b;
    logic [3:0]  r, g, b;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata, mem_rdata;
    logic        wr_valid, wr_ready, wr_drop;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        clear_req, clear_busy, clear_done;

    int   checks   = 0;
    int   failures = 0;
    logic ready_s;

    logic [11:0] shadow [0:FB_SIZE-1];
    logic [15:0] ram    [0:32767];
    int          hits   [0:FB_SIZE-1];

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        wv;
        logic [14:0] wa;
        logic [11:0] wd;
        logic        exp_ready;
        logic [14:0] exp_addr;
        logic        exp_we;
        logic        exp_drop;
    } vec_t;

    vga_fb_arbiter dut (
        .vgaclk(vgaclk), .reset_n(reset_n), .hcnt(hcnt), .vcnt(vcnt),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_b_i(blank_b_i),
        .hsync(hsync), .vsync(vsync), .blank_b(blank_b), .sync_b(sync_b),
        .r(r), .g(g), .b(b),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_drop(wr_drop), .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done)
    );

    always #5 vgaclk = ~vgaclk;

    // Single-port RAM with one-cycle registered read.
    always @(posedge vgaclk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        #1;
        ready_s = wr_ready;
        @(posedge vgaclk);
        #1;
    endtask

    task automatic idle();
        hcnt = 10'd700; vcnt = 10'd0;
        hsync_i = 1'b1; vsync_i = 1'b1; blank_b_i = 1'b0;
        wr_valid = 1'b0; clear_req = 1'b0;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_timing"}, 32'({hsync, vsync, blank_b, sync_b}), 32'b1101);
        chk({nm, "_rgb"},    32'({r, g, b}), 32'h0);
        chk({nm, "_addr"},   32'(mem_addr), 32'h0);
        chk({nm, "_flags"},  32'({mem_we, wr_drop, clear_busy, clear_done}), 32'h0);
    endtask

    initial begin
        vec_t        vt [12];
        logic        bl_t [0:14], hs_t [0:14], vs_t [0:14];
        logic [14:0] obs_addr [0:14];
        logic        bl_r [0:NR-1], hs_r [0:NR-1], vs_r [0:NR-1];
        logic [11:0] px_r [0:NR-1];
        logic [11:0] cur_pix, exp_px;
        logic [14:0] exp_addr;
        logic        found, disp, ew;
        int          cnt, err1, err2, err3, err4, done_cnt, n;

        vt[0]  = '{10'd8,   10'd4,   1'b0, 15'd0,     12'h000, 1'b0, 15'd162,   1'b0, 1'b0};
        vt[1]  = '{10'd636, 10'd479, 1'b1, 15'd5,     12'h111, 1'b0, 15'd19199, 1'b0, 1'b0};
        vt[2]  = '{10'd640, 10'd0,   1'b0, 15'd5,     12'h111, 1'b1, 15'd19199, 1'b0, 1'b0};
        vt[3]  = '{10'd640, 10'd0,   1'b1, 15'd100,   12'h123, 1'b1, 15'd100,   1'b1, 1'b0};
        vt[4]  = '{10'd641, 10'd10,  1'b1, 15'd19200, 12'hABC, 1'b1, 15'd19200, 1'b0, 1'b1};
        vt[5]  = '{10'd5,   10'd0,   1'b1, 15'd7,     12'h456, 1'b1, 15'd7,     1'b1, 1'b0};
        vt[6]  = '{10'd4,   10'd480, 1'b0, 15'd7,     12'h456, 1'b1, 15'd7,     1'b0, 1'b0};
        vt[7]  = '{10'd0,   10'd0,   1'b1, 15'd50,    12'h777, 1'b0, 15'd0,     1'b0, 1'b0};
        vt[8]  = '{10'd639, 10'd0,   1'b1, 15'd19199, 12'h789, 1'b1, 15'd19199, 1'b1, 1'b0};
        vt[9]  = '{10'd700, 10'd500, 1'b1, 15'd32767, 12'hDEF, 1'b1, 15'd32767, 1'b0, 1'b1};
        vt[10] = '{10'd12,  10'd479, 1'b0, 15'd0,     12'h000, 1'b0, 15'd19043, 1'b0, 1'b0};
        vt[11] = '{10'd799, 10'd524, 1'b1, 15'd300,   12'h0F0, 1'b1, 15'd300,   1'b1, 1'b0};

        for (int i = 0; i < FB_SIZE; i++) shadow[i] = 12'h000;
        idle();
        wr_addr = '0; wr_data = '0;

        // Reset state, held several cycles.
        reset_n = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_no_we", 32'(mem_we), 32'h0);
        end
        chk_reset("reset");

        // Automatic clear after reset.
        reset_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 25000; i++) begin
            tick();
            if (clear_done) begin found = 1'b1; break; end
        end
        chk("boot_clear_done", 32'(found), 32'h1);
        repeat (3) tick();

        // T1: two pixels, colour/sync alignment.
        wr_valid = 1'b1; wr_addr = 15'd0; wr_data = 12'hF00; tick();
        chk("t1_wr0_ready", 32'(ready_s), 32'h1);
        wr_addr = 15'd1; wr_data = 12'h0F0; tick();
        chk("t1_wr1_ready", 32'(ready_s), 32'h1);
        shadow[0] = 12'hF00; shadow[1] = 12'h0F0;
        idle();
        repeat (4) tick();
        for (int k = 0; k < 15; k++) begin
            int j;
            obs_addr[k] = mem_addr;
            j = k - 3;
            if (j < 0) begin
                chk("t1_sync", 32'({hsync, vsync, blank_b}), 32'b110);
                chk("t1_rgb",  32'({r, g, b}), 32'h0);
            end else begin
                exp_px = !bl_t[j] ? 12'h000 : (j < 4) ? 12'hF00 : 12'h0F0;
                chk("t1_sync", 32'({hsync, vsync, blank_b}), 32'({hs_t[j], vs_t[j], bl_t[j]}));
                chk("t1_rgb",  32'({r, g, b}), 32'(exp_px));
            end
            if (k < 12) begin
                bl_t[k] = (k < 8); hs_t[k] = !(k >= 2 && k <= 4); vs_t[k] = (k != 6);
                hcnt = 10'(k); vcnt = 10'd0;
            end else begin
                bl_t[k] = 1'b0; hs_t[k] = 1'b1; vs_t[k] = 1'b1;
                hcnt = 10'd700;
            end
            blank_b_i = bl_t[k]; hsync_i = hs_t[k]; vsync_i = vs_t[k];
            tick();
        end
        chk("t1_addr_fetch0", 32'(obs_addr[1]), 32'd0);
        chk("t1_addr_fetch1", 32'(obs_addr[5]), 32'd1);

        // T2/T4: table of single-cycle arbitration vectors.
        idle();
        for (int i = 0; i < 12; i++) begin
            hcnt = vt[i].h; vcnt = vt[i].v;
            wr_valid = vt[i].wv; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            tick();
            chk($sformatf("vec%0d_ready", i), 32'(ready_s), 32'(vt[i].exp_ready));
            chk($sformatf("vec%0d_addr", i),  32'(mem_addr), 32'(vt[i].exp_addr));
            chk($sformatf("vec%0d_we", i),    32'(mem_we), 32'(vt[i].exp_we));
            chk($sformatf("vec%0d_drop", i),  32'(wr_drop), 32'(vt[i].exp_drop));
            if (vt[i].exp_we) begin
                chk($sformatf("vec%0d_wdata", i), 32'(mem_wdata), 32'({4'h0, vt[i].wd}));
                shadow[vt[i].wa] = vt[i].wd;
            end
        end

        // Randomised traffic against the framebuffer model.
        exp_addr = 15'd300;
        cur_pix  = shadow[19043];
        for (int k = 0; k < NR; k++) begin
            logic [9:0] h, v;
            h = (($urandom % 2) == 0) ? 10'($urandom_range(0, 639)) : 10'($urandom_range(0, 799));
            v = (($urandom % 4) != 0) ? 10'($urandom_range(0, 479)) : 10'($urandom_range(0, 524));
            hcnt = h; vcnt = v;
            wr_valid = (($urandom % 4) != 0);
            wr_addr  = (($urandom % 8) == 0) ? 15'($urandom_range(19200, 32767))
                                             : 15'($urandom_range(0, 19199));
            wr_data  = 12'($urandom);
            bl_r[k] = 1'($urandom); hs_r[k] = 1'($urandom); vs_r[k] = 1'($urandom);
            blank_b_i = bl_r[k]; hsync_i = hs_r[k]; vsync_i = vs_r[k];
            disp = (h < 640) && (v < 480) && (h % 4 == 0);
            ew = 1'b0;
            if (disp) begin
                exp_addr = 15'((v / 4) * 160 + h / 4);
                cur_pix  = shadow[exp_addr];
            end else if (wr_valid) begin
                exp_addr = wr_addr;
                ew = (wr_addr < 15'(FB_SIZE));
            end
            px_r[k] = cur_pix;
            tick();
            chk("rnd_ready", 32'(ready_s), 32'(!disp));
            chk("rnd_addr",  32'(mem_addr), 32'(exp_addr));
            chk("rnd_we",    32'(mem_we), 32'(ew));
            chk("rnd_drop",  32'(wr_drop), 32'(!disp && wr_valid && !ew));
            if (ew) begin
                chk("rnd_wdata", 32'(mem_wdata), 32'({4'h0, wr_data}));
                shadow[wr_addr] = wr_data;
            end
            if (k >= 2) begin
                chk("rnd_sync", 32'({hsync, vsync, blank_b}), 32'({hs_r[k-2], vs_r[k-2], bl_r[k-2]}));
                chk("rnd_rgb",  32'({r, g, b}), 32'(bl_r[k-2] ? px_r[k-2] : 12'h000));
            end
        end

        // T3: writer saturating a full active line.
        idle();
        tick();
        err1 = 0; err2 = 0; err3 = 0; cnt = 0;
        vcnt = 10'd10;
        for (int h = 0; h < 800; h++) begin
            hcnt = 10'(h); blank_b_i = (h < 640);
            wr_valid = 1'b1; wr_addr = 15'($urandom_range(0, 19199)); wr_data = 12'($urandom);
            disp = (h < 640) && (h % 4 == 0);
            tick();
            if (ready_s !== !disp) err1++;
            if (!ready_s) cnt++;
            if (disp && mem_we) err2++;
            if (disp && mem_addr !== 15'(10 / 4 * 160 + h / 4)) err3++;
            if (!disp) shadow[wr_addr] = wr_data;
        end
        chk("t3_ready_pattern_errs", 32'(err1), 32'd0);
        chk("t3_fetch_slots", 32'(cnt), 32'd160);
        chk("t3_we_on_fetch", 32'(err2), 32'd0);
        chk("t3_fetch_addr_errs", 32'(err3), 32'd0);

        // Readback of the whole buffer against the model.
        idle();
        repeat (2) tick();
        err1 = 0;
        for (int i = 0; i < FB_SIZE; i++) if (ram[i] !== {4'h0, shadow[i]}) err1++;
        chk("readback_errs", 32'(err1), 32'd0);

        // T5: clear request with a simultaneous committed write; second request ignored.
        clear_req = 1'b1; wr_valid = 1'b1; wr_addr = 15'd300; wr_data = 12'hABC;
        tick();
        chk("t5_sametime_ready", 32'(ready_s), 32'h1);
        chk("t5_sametime_write", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 15'd300, 16'h0ABC}));
        clear_req = 1'b0;
        for (int i = 0; i < FB_SIZE; i++) hits[i] = 0;
        err1 = 0; err2 = 0; err3 = 0; err4 = 0; done_cnt = 0; found = 1'b0;
        vcnt = 10'd0;
        n = 0;
        while (n < 30000 && !found) begin
            int hc;
            hc = n % 800;
            hcnt = 10'(hc); blank_b_i = (hc < 640);
            wr_valid = 1'b1; wr_addr = 15'($urandom_range(0, 19199));
            clear_req = (n == 1000);
            disp = (hc < 640) && (hc % 4 == 0);
            tick();
            if (ready_s) err1++;
            if (disp && mem_we) err2++;
            if (mem_we) begin
                if (mem_addr < 15'(FB_SIZE)) hits[mem_addr]++;
                else err3++;
                if (mem_wdata !== 16'h0000) err4++;
            end
            if (n == 3) chk("t5_busy", 32'(clear_busy), 32'h1);
            if (clear_done) begin done_cnt++; found = 1'b1; end
            n++;
        end
        chk("t5_done_seen", 32'(found), 32'h1);
        idle();
        cnt = 0;
        repeat (10) begin
            tick();
            if (mem_we) cnt++;
            if (clear_done) done_cnt++;
        end
        chk("t5_ready_during_clear", 32'(err1), 32'd0);
        chk("t5_we_on_disp", 32'(err2), 32'd0);
        chk("t5_bad_addr", 32'(err3), 32'd0);
        chk("t5_bad_data", 32'(err4), 32'd0);
        chk("t5_done_pulses", 32'(done_cnt), 32'd1);
        chk("t5_writes_after_done", 32'(cnt), 32'd0);
        chk("t5_busy_after", 32'(clear_busy), 32'h0);
        chk("t5_ready_after", 32'(ready_s), 32'h1);
        err1 = 0;
        for (int i = 0; i < FB_SIZE; i++) if (hits[i] != 1) err1++;
        chk("t5_addr_not_once", 32'(err1), 32'd0);

        // T6: reset in the middle of a clear.
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (mem_we && mem_addr == 15'd5000) begin found = 1'b1; break; end
        end
        chk("t6_reached_5000", 32'(found), 32'h1);
        hsync_i = 1'b0; vsync_i = 1'b0; blank_b_i = 1'b1; hcnt = 10'd700;
        reset_n = 1'b0;
        tick();
        chk_reset("t6_reset");
        reset_n = 1'b1; idle();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_we) begin found = 1'b1; break; end
        end
        chk("t6_restart_write", 32'(found), 32'h1);
        chk("t6_restart_addr0", 32'(mem_addr), 32'd0);
        tick();
        chk("t6_next_addr1", 32'({mem_we, mem_addr}), 32'({1'b1, 15'd1}));
        chk("t6_busy", 32'(clear_busy), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
